// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, index-width helper and per-beat tag type for the FFT power/peak path
// Contents:
//    NFFT_DEF, DW_DEF - default transform length and component width
//    log2n()          - bin index width for a given transform length
//    beat_tag_t       - first/last flags carried down the pipe beside each beat
package fft_pkg;

   localparam int NFFT_DEF = 16;
   localparam int DW_DEF   = 16;

   function automatic int log2n(input int n);
      return $clog2(n);
   endfunction

   // Tags ride alongside the data so that the tracker in the output stage
   // never depends on the input-side counter, which may already be in the
   // next frame.
   typedef struct packed {
      logic last;
      logic first;
   } beat_tag_t;

endpackage

// File: rtl/fft_cplx_sq.sv
// rtl/fft_cplx_sq.sv - two-stage pipelined re^2 + im^2 with a shared stage enable
// Ports:
//    i_clk, i_rst_n - clock, async active-low reset
//    i_en           - shift both stages this cycle
//    i_re, i_im     - signed components, DW bits each
//    o_pwr          - registered unsigned power, 2*DW bits, two cycles after input
module fft_cplx_sq
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic [DW-1:0]   i_re,
   input  logic [DW-1:0]   i_im,
   output logic [2*DW-1:0] o_pwr
);

   // Sign-extend to the full product width so the low 2*DW bits of the
   // product are exact, including (-2^(DW-1))^2 = 2^(2DW-2).
   logic signed [2*DW-1:0] w_re_x;
   logic signed [2*DW-1:0] w_im_x;
   logic signed [2*DW-1:0] w_re2;
   logic signed [2*DW-1:0] w_im2;
   logic        [2*DW-1:0] r_re2;
   logic        [2*DW-1:0] r_im2;
   logic        [2*DW-1:0] r_pwr;

   assign w_re_x = {{DW{i_re[DW-1]}}, i_re};
   assign w_im_x = {{DW{i_im[DW-1]}}, i_im};
   assign w_re2  = w_re_x * w_re_x;
   assign w_im2  = w_im_x * w_im_x;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_re2 <= '0;
         r_im2 <= '0;
         r_pwr <= '0;
      end else if (i_en) begin
         r_re2 <= w_re2;
         r_im2 <= w_im2;
         // Each square is at most 2^(2DW-2), so the sum fits 2*DW unsigned.
         r_pwr <= r_re2 + r_im2;
      end
   end

   assign o_pwr = r_pwr;

endmodule

// File: rtl/fft_power_peak.sv
// rtl/fft_power_peak.sv - per-bin power stream of FFT output with per-frame peak bin/power report
// Ports:
//    aclk, aresetn                    - clock, async active-low reset
//    s_data/s_valid/s_last/s_ready    - complex bin input {im, re}
//    m_data/m_valid/m_last/m_ready    - unsigned power output, m_last on frame-closing bin
//    peak_bin/peak_power/peak_valid   - peak of last completed frame, 1-cycle update pulse
//    frame_err                        - sticky framing error, cleared only by reset
module fft_power_peak
   import fft_pkg::*;
#(
   parameter int NFFT = NFFT_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [2*DW-1:0]        s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [2*DW-1:0]        m_data,
   output logic                   m_valid,
   output logic                   m_last,
   input  logic                   m_ready,
   output logic [log2n(NFFT)-1:0] peak_bin,
   output logic [2*DW-1:0]        peak_power,
   output logic                   peak_valid,
   output logic                   frame_err
);

   localparam int LOG2N = log2n(NFFT);

   logic [LOG2N-1:0] r_bin_cnt;
   logic             r_v1;
   logic             r_v2;
   beat_tag_t        r_tag1;
   beat_tag_t        r_tag2;
   logic [LOG2N-1:0] r_idx1;
   logic [LOG2N-1:0] r_idx2;
   logic [2*DW-1:0]  r_run_max;
   logic [LOG2N-1:0] r_run_idx;
   logic [LOG2N-1:0] r_peak_bin;
   logic [2*DW-1:0]  r_peak_power;
   logic             r_peak_valid;
   logic             r_frame_err;

   logic             w_adv;
   logic             w_acc;
   logic             w_at_end;
   logic             w_close;
   logic             w_hs;
   logic             w_take;
   logic [2*DW-1:0]  w_pwr;
   logic [2*DW-1:0]  w_new_max;
   logic [LOG2N-1:0] w_new_idx;

   // Stall-all: every stage moves together whenever the output register
   // is free or being drained.
   assign w_adv    = !r_v2 || m_ready;
   assign s_ready  = aresetn && w_adv;
   assign w_acc    = s_valid && s_ready;
   assign w_at_end = (r_bin_cnt == LOG2N'(NFFT - 1));
   assign w_close  = s_last || w_at_end;
   assign w_hs     = r_v2 && m_ready;

   // Strictly-greater replacement keeps the lowest index on ties.
   assign w_take    = r_tag2.first || (w_pwr > r_run_max);
   assign w_new_max = w_take ? w_pwr  : r_run_max;
   assign w_new_idx = w_take ? r_idx2 : r_run_idx;

   fft_cplx_sq #(.DW(DW)) u_sq (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_en    (w_adv),
      .i_re    (s_data[DW-1:0]),
      .i_im    (s_data[2*DW-1:DW]),
      .o_pwr   (w_pwr)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_bin_cnt    <= '0;
         r_v1         <= 1'b0;
         r_v2         <= 1'b0;
         r_tag1       <= '0;
         r_tag2       <= '0;
         r_idx1       <= '0;
         r_idx2       <= '0;
         r_run_max    <= '0;
         r_run_idx    <= '0;
         r_peak_bin   <= '0;
         r_peak_power <= '0;
         r_peak_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_peak_valid <= 1'b0;

         if (w_acc) begin
            r_bin_cnt <= w_close ? '0 : r_bin_cnt + LOG2N'(1);
            // Mismatch either way: early s_last, or a full frame without it.
            if (s_last != w_at_end) begin
               r_frame_err <= 1'b1;
            end
         end

         if (w_adv) begin
            r_v1        <= w_acc;
            r_tag1.last  <= w_acc && w_close;
            r_tag1.first <= w_acc && (r_bin_cnt == '0);
            r_idx1      <= r_bin_cnt;
            r_v2        <= r_v1;
            r_tag2      <= r_tag1;
            r_idx2      <= r_idx1;
         end

         if (w_hs) begin
            r_run_max <= w_new_max;
            r_run_idx <= w_new_idx;
            if (r_tag2.last) begin
               r_peak_bin   <= w_new_idx;
               r_peak_power <= w_new_max;
               r_peak_valid <= 1'b1;
            end
         end
      end
   end

   assign m_data     = w_pwr;
   assign m_valid    = r_v2;
   assign m_last     = r_tag2.last;
   assign peak_bin   = r_peak_bin;
   assign peak_power = r_peak_power;
   assign peak_valid = r_peak_valid;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_power_peak.sv
// tb/tb_fft_power_peak.sv - scoreboard bench for fft_power_peak
module tb_fft_power_peak;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic [3:0]  peak_bin;
   logic [31:0] peak_power;
   logic        peak_valid;
   logic        frame_err;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] d;
      logic        l;
      int          t;
   } exp_t;

   logic [31:0] in_d[$];
   logic        in_l[$];
   exp_t        exp_q[$];
   logic [3:0]  pk_bin_q[$];
   logic [31:0] pk_pow_q[$];

   int          m_cnt = 0;
   logic [31:0] m_max = '0;
   int          m_idx = 0;
   logic        m_err = 1'b0;

   fft_power_peak #(.NFFT(16), .DW(16)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_ready    (s_ready),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .peak_bin   (peak_bin),
      .peak_power (peak_power),
      .peak_valid (peak_valid),
      .frame_err  (frame_err)
   );

   always #5 aclk = ~aclk;

   task automatic push_beat(input logic [15:0] re, input logic [15:0] im, input logic last);
      in_d.push_back({im, re});
      in_l.push_back(last);
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_err = 1'b0;
      in_d.delete();
      in_l.delete();
      exp_q.delete();
      pk_bin_q.delete();
      pk_pow_q.delete();
   endtask

   // Streams all queued beats; vmode 1 = random s_valid, rmode 1 = m_ready toggling.
   task automatic run_stream(input int vmode, input int rmode, input bit chk_lat, input string nm);
      int          cyc;
      int          tail;
      exp_t        e;
      logic signed [15:0] re;
      logic signed [15:0] im;
      longint      p;
      logic        at_end;
      logic        cl;
      cyc  = 0;
      tail = 0;
      while (!(in_d.size() == 0 && exp_q.size() == 0 && tail >= 4) && cyc < 3000) begin
         if (in_d.size() > 0 && (vmode == 0 || $urandom_range(0, 1) == 1)) begin
            s_valid = 1'b1;
            s_data  = in_d[0];
            s_last  = in_l[0];
         end else begin
            s_valid = 1'b0;
            s_data  = '0;
            s_last  = 1'b0;
         end
         m_ready = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
         #1;
         if (peak_valid) begin
            n_vec++;
            if (pk_bin_q.size() == 0) begin
               n_err++;
               $display("FAIL %s unexpected peak_valid: got bin %0d power %08h, required none", nm, peak_bin, peak_power);
            end else begin
               if (peak_bin !== pk_bin_q[0] || peak_power !== pk_pow_q[0]) begin
                  n_err++;
                  $display("FAIL %s peak: got bin %0d power %08h, required bin %0d power %08h",
                           nm, peak_bin, peak_power, pk_bin_q[0], pk_pow_q[0]);
               end
               void'(pk_bin_q.pop_front());
               void'(pk_pow_q.pop_front());
            end
         end
         if (m_valid && m_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra output beat: got %08h last %0b, required none", nm, m_data, m_last);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e.d || m_last !== e.l) begin
                  n_err++;
                  $display("FAIL %s beat: got %08h last %0b, required %08h last %0b", nm, m_data, m_last, e.d, e.l);
               end
               if (chk_lat && cyc != e.t + 2) begin
                  n_err++;
                  $display("FAIL %s latency: got %0d cycles, required 2", nm, cyc - e.t);
               end
            end
         end
         if (s_valid && s_ready) begin
            re = s_data[15:0];
            im = s_data[31:16];
            p  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            at_end = (m_cnt == 15);
            cl     = s_last || at_end;
            if (s_last != at_end) m_err = 1'b1;
            if (m_cnt == 0 || p[31:0] > m_max) begin
               m_max = p[31:0];
               m_idx = m_cnt;
            end
            e.d = p[31:0];
            e.l = cl;
            e.t = cyc;
            exp_q.push_back(e);
            if (cl) begin
               pk_bin_q.push_back(4'(m_idx));
               pk_pow_q.push_back(m_max);
            end
            m_cnt = cl ? 0 : m_cnt + 1;
            void'(in_d.pop_front());
            void'(in_l.pop_front());
         end
         if (in_d.size() == 0 && exp_q.size() == 0) tail++;
         @(negedge aclk);
         cyc++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      n_vec++;
      if (cyc >= 3000) begin
         n_err++;
         $display("FAIL %s timeout: %0d beats and %0d outputs outstanding, required 0", nm, in_d.size(), exp_q.size());
      end
      n_vec++;
      if (pk_bin_q.size() != 0) begin
         n_err++;
         $display("FAIL %s missing peak_valid pulses: got %0d outstanding, required 0", nm, pk_bin_q.size());
      end
      n_vec++;
      if (frame_err !== m_err) begin
         n_err++;
         $display("FAIL %s frame_err: got %0b, required %0b", nm, frame_err, m_err);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'h1234_5678;
      s_last  = 1'b0;
      m_ready = 1'b1;
      repeat (5) @(negedge aclk);
      #1;
      n_vec++;
      if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset s_ready: got %0b, required 0", s_ready); end
      n_vec++;
      if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset m_valid: got %0b, required 0", m_valid); end
      n_vec++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset frame_err: got %0b, required 0", frame_err); end
      n_vec++;
      if (peak_valid !== 1'b0) begin n_err++; $display("FAIL reset peak_valid: got %0b, required 0", peak_valid); end
      s_valid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      model_reset();
   endtask

   task automatic load_ramp();
      for (int k = 0; k < 16; k++) push_beat(16'(k * 256), 16'h0000, k == 15);
   endtask

   task automatic test_single_frame();
      load_ramp();
      run_stream(0, 0, 1'b1, "single");
      n_vec++;
      if (peak_bin !== 4'd15 || peak_power !== 32'h00E1_0000) begin
         n_err++;
         $display("FAIL single final peak: got bin %0d power %08h, required bin 15 power 00e10000", peak_bin, peak_power);
      end
   endtask

   task automatic test_extreme();
      push_beat(16'h8000, 16'h8000, 1'b0);
      push_beat(16'h7FFF, 16'h8000, 1'b0);
      for (int k = 2; k < 16; k++) push_beat(16'($urandom), 16'($urandom), k == 15);
      run_stream(0, 0, 1'b1, "extreme");
   endtask

   task automatic test_backpressure();
      load_ramp();
      load_ramp();
      run_stream(1, 1, 1'b0, "backpressure");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 16; k++) push_beat((k == 3 || k == 9) ? 16'h0020 : 16'h0001, 16'h0000, k == 15);
      for (int k = 0; k < 16; k++) push_beat((k == 0) ? 16'h0040 : 16'h0002, 16'h0000, k == 15);
      run_stream(0, 0, 1'b1, "back_to_back");
      n_vec++;
      if (peak_bin !== 4'd0 || peak_power !== 32'h0000_1000) begin
         n_err++;
         $display("FAIL back_to_back final peak: got bin %0d power %08h, required bin 0 power 00001000", peak_bin, peak_power);
      end
   endtask

   task automatic test_frame_err();
      int n_pk;
      for (int k = 0; k < 8; k++) push_beat(16'(k + 1), 16'(k), k == 7);
      for (int k = 0; k < 16; k++) push_beat(16'((k * 37) % 200), 16'(k), k == 15);
      run_stream(0, 0, 1'b1, "frame_err");
      n_vec++;
      if (frame_err !== 1'b1) begin n_err++; $display("FAIL frame_err sticky: got %0b, required 1", frame_err); end

      // Partial frame, then reset before it closes.
      n_pk    = 0;
      m_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_data  = {16'h0000, 16'(k * 100)};
         s_last  = 1'b0;
         @(negedge aclk);
         if (peak_valid) n_pk++;
      end
      s_valid = 1'b0;
      aresetn = 1'b0;
      repeat (3) begin
         @(negedge aclk);
         if (peak_valid) n_pk++;
      end
      #1;
      n_vec++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL midreset frame_err: got %0b, required 0", frame_err); end
      n_vec++;
      if (m_valid !== 1'b0) begin n_err++; $display("FAIL midreset m_valid: got %0b, required 0", m_valid); end
      aresetn = 1'b1;
      @(negedge aclk);
      if (peak_valid) n_pk++;
      n_vec++;
      if (n_pk != 0) begin n_err++; $display("FAIL midreset peak_valid pulses: got %0d, required 0", n_pk); end
      model_reset();
      for (int k = 0; k < 16; k++) push_beat(16'((k == 6) ? 300 : k), 16'h0000, k == 15);
      run_stream(0, 0, 1'b1, "after_reset");
   endtask

   initial begin
      aresetn = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      @(negedge aclk);
      test_reset();
      test_single_frame();
      test_extreme();
      test_backpressure();
      test_back_to_back();
      test_frame_err();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
